// File: rtl/fifo_out3_if.sv
// Byte-in / word-out bundle for the padded-stream receive FIFO.
// The master drives bytes and pop requests; the slave returns words and status.
interface fifo_out3_if #(
    parameter int DATA_WIDTH = 8
);
    logic                      in_valid;
    logic [DATA_WIDTH-1:0]     in_data;
    logic                      in_ready;
    logic                      read_en;
    logic [4*DATA_WIDTH-1:0]   read_data;
    logic                      full;
    logic                      empty;
    logic                      pad_err;

    modport master (
        output in_valid, in_data, read_en,
        input  in_ready, read_data, full, empty, pad_err
    );

    modport slave (
        input  in_valid, in_data, read_en,
        output in_ready, read_data, full, empty, pad_err
    );
endinterface

// File: rtl/fifo_out3.sv
// Strips the lead/trail zero pads from each byte group, packs the data bytes
// big-endian into one word and queues the words for the downstream reader.
module fifo_out3 #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int LEAD_PAD   = 2,
    parameter int TRAIL_PAD  = 1
) (
    input logic        clk,
    input logic        rst,
    fifo_out3_if.slave bus
);
    localparam int GRP   = LEAD_PAD + 4 + TRAIL_PAD;
    localparam int POS_W = (GRP > 1) ? $clog2(GRP) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [POS_W-1:0] POS_FIRST_DATA = POS_W'(LEAD_PAD);
    localparam logic [POS_W-1:0] POS_LAST_DATA  = POS_W'(LEAD_PAD + 3);
    localparam logic [POS_W-1:0] POS_END        = POS_W'(GRP - 1);
    localparam logic [PTR_W-1:0] PTR_LAST       = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL       = CNT_W'(DEPTH);

    logic [POS_W-1:0]        r_pos;
    logic [3*DATA_WIDTH-1:0] r_asm;
    logic [4*DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]        r_wrPtr;
    logic [PTR_W-1:0]        r_rdPtr;
    logic [CNT_W-1:0]        r_count;
    logic [4*DATA_WIDTH-1:0] r_readData;
    logic                    r_padErr;

    logic w_full;
    logic w_empty;
    logic w_inReady;
    logic w_accept;
    logic w_isData;
    logic w_push;
    logic w_pop;

    assign w_full    = (r_count == CNT_FULL);
    assign w_empty   = (r_count == '0);
    // Only the byte that completes a word can be stalled; pads always drain.
    assign w_inReady = !((r_pos == POS_LAST_DATA) && w_full);
    assign w_accept  = bus.in_valid && w_inReady;
    assign w_isData  = (r_pos >= POS_FIRST_DATA) && (r_pos <= POS_LAST_DATA);
    assign w_push    = w_accept && (r_pos == POS_LAST_DATA);
    assign w_pop     = bus.read_en && !w_empty;

    assign bus.in_ready  = w_inReady;
    assign bus.read_data = r_readData;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.pad_err   = r_padErr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pos    <= '0;
            r_asm    <= '0;
            r_padErr <= 1'b0;
        end else if (w_accept) begin
            r_pos <= (r_pos == POS_END) ? '0 : r_pos + 1'b1;
            if (!w_isData && (bus.in_data != '0)) begin
                r_padErr <= 1'b1;
            end
            if (w_isData && !w_push) begin
                r_asm <= {r_asm[2*DATA_WIDTH-1:0], bus.in_data};
            end
        end
    end

    // The last data byte bypasses the assembly register straight into storage.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {r_asm, bus.in_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_readData <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= (r_wrPtr == PTR_LAST) ? '0 : r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr    <= (r_rdPtr == PTR_LAST) ? '0 : r_rdPtr + 1'b1;
                r_readData <= r_mem[r_rdPtr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_out3.sv
// Scoreboard bench for fifo_out3: expected words are queued as groups are sent
// and compared as they are popped.
module tb_fifo_out3;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] sb[$];
    logic [31:0] lastRead = '0;

    fifo_out3_if #(.DATA_WIDTH(DW)) ifc ();

    fifo_out3 #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .LEAD_PAD  (2),
        .TRAIL_PAD (1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        int guard;
        guard = 0;
        ifc.in_valid = 1'b1;
        ifc.in_data  = b;
        while (!ifc.in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            failures++;
            $display("[TB] FAIL send_timeout: in_ready=%0b required 1 for byte %h", ifc.in_ready, b);
        end
        tick();
        ifc.in_valid = 1'b0;
    endtask

    task automatic sendGroup(input logic [7:0] p0, input logic [7:0] p1,
                             input logic [31:0] w, input logic [7:0] p2);
        sb.push_back(w);
        sendByte(p0);
        sendByte(p1);
        sendByte(w[31:24]);
        sendByte(w[23:16]);
        sendByte(w[15:8]);
        sendByte(w[7:0]);
        sendByte(p2);
    endtask

    task automatic popWord();
        ifc.read_en = 1'b1;
        tick();
        ifc.read_en = 1'b0;
    endtask

    task automatic test_reset();
        ifc.in_valid = 1'b0;
        ifc.in_data  = '0;
        ifc.read_en  = 1'b0;
        rst = 1'b0;
        tick(); tick(); tick();
        checks++; if (ifc.read_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_read_data: got %h expected 0", ifc.read_data); end
        checks++; if (ifc.full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full: got %b expected 0", ifc.full); end
        checks++; if (ifc.empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty: got %b expected 1", ifc.empty); end
        checks++; if (ifc.pad_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_pad_err: got %b expected 0", ifc.pad_err); end
        checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", ifc.in_ready); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic_unpack();
        logic [31:0] exp;
        sb.push_back(32'hDEADBEEF);
        sendByte(8'h00); sendByte(8'h00); sendByte(8'hDE); sendByte(8'hAD); sendByte(8'hBE);
        checks++; if (ifc.empty !== 1'b1) begin failures++; $display("[TB] FAIL basic_empty_before: got %b expected 1", ifc.empty); end
        sendByte(8'hEF);
        checks++; if (ifc.empty !== 1'b0) begin failures++; $display("[TB] FAIL basic_empty_after: got %b expected 0", ifc.empty); end
        sendByte(8'h00);
        popWord();
        exp = sb.pop_front();
        checks++; if (ifc.read_data !== exp) begin failures++; $display("[TB] FAIL basic_word: got %h expected %h", ifc.read_data, exp); end
        lastRead = exp;
        checks++; if (ifc.empty !== 1'b1) begin failures++; $display("[TB] FAIL basic_empty_final: got %b expected 1", ifc.empty); end
        checks++; if (ifc.pad_err !== 1'b0) begin failures++; $display("[TB] FAIL basic_pad_err: got %b expected 0", ifc.pad_err); end
    endtask

    task automatic test_fill_backpressure();
        logic [31:0] words [5];
        logic [31:0] exp;
        words[0] = 32'h01020304; words[1] = 32'h11121314; words[2] = 32'h21222324;
        words[3] = 32'h31323334; words[4] = 32'h41424344;
        for (int i = 0; i < 4; i++) sendGroup(8'h00, 8'h00, words[i], 8'h00);
        checks++; if (ifc.full !== 1'b1) begin failures++; $display("[TB] FAIL fill_full: got %b expected 1", ifc.full); end
        checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL fill_pad_ready: got %b expected 1", ifc.in_ready); end
        sb.push_back(words[4]);
        sendByte(8'h00); sendByte(8'h00); sendByte(8'h41); sendByte(8'h42); sendByte(8'h43);
        ifc.in_valid = 1'b1;
        ifc.in_data  = 8'h44;
        tick(); tick();
        checks++; if (ifc.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_ready: got %b expected 0", ifc.in_ready); end
        checks++; if (ifc.full !== 1'b1) begin failures++; $display("[TB] FAIL stall_full: got %b expected 1", ifc.full); end
        popWord();
        exp = sb.pop_front();
        checks++; if (ifc.read_data !== exp) begin failures++; $display("[TB] FAIL stall_pop_word: got %h expected %h", ifc.read_data, exp); end
        lastRead = exp;
        checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL resume_ready: got %b expected 1", ifc.in_ready); end
        tick();
        ifc.in_valid = 1'b0;
        checks++; if (ifc.full !== 1'b1) begin failures++; $display("[TB] FAIL resume_full: got %b expected 1", ifc.full); end
        sendByte(8'h00);
        for (int i = 0; i < 4; i++) begin
            popWord();
            exp = sb.pop_front();
            checks++; if (ifc.read_data !== exp) begin failures++; $display("[TB] FAIL drain_word%0d: got %h expected %h", i, ifc.read_data, exp); end
            lastRead = exp;
        end
        checks++; if (ifc.empty !== 1'b1) begin failures++; $display("[TB] FAIL drain_empty: got %b expected 1", ifc.empty); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] w;
        logic [31:0] exp;
        sendGroup(8'h00, 8'h00, 32'hA0A1A2A3, 8'h00);
        sendGroup(8'h00, 8'h00, 32'hB0B1B2B3, 8'h00);
        for (int g = 0; g < 10; g++) begin
            w = 32'h5A3C9600 ^ (g * 32'h01030507);
            sb.push_back(w);
            sendByte(8'h00); sendByte(8'h00);
            sendByte(w[31:24]); sendByte(w[23:16]); sendByte(w[15:8]);
            ifc.in_valid = 1'b1;
            ifc.in_data  = w[7:0];
            ifc.read_en  = 1'b1;
            tick();
            ifc.in_valid = 1'b0;
            ifc.read_en  = 1'b0;
            exp = sb.pop_front();
            checks++; if (ifc.read_data !== exp) begin failures++; $display("[TB] FAIL simul_word%0d: got %h expected %h", g, ifc.read_data, exp); end
            lastRead = exp;
            sendByte(8'h00);
        end
        popWord();
        exp = sb.pop_front();
        checks++; if (ifc.read_data !== exp) begin failures++; $display("[TB] FAIL simul_drain0: got %h expected %h", ifc.read_data, exp); end
        checks++; if (ifc.empty !== 1'b0) begin failures++; $display("[TB] FAIL simul_count_one: empty got %b expected 0", ifc.empty); end
        popWord();
        exp = sb.pop_front();
        checks++; if (ifc.read_data !== exp) begin failures++; $display("[TB] FAIL simul_drain1: got %h expected %h", ifc.read_data, exp); end
        lastRead = exp;
        checks++; if (ifc.empty !== 1'b1) begin failures++; $display("[TB] FAIL simul_count_zero: empty got %b expected 1", ifc.empty); end
    endtask

    task automatic test_pad_error();
        logic [31:0] exp;
        sb.push_back(32'hAABBCCDD);
        sendByte(8'h00);
        checks++; if (ifc.pad_err !== 1'b0) begin failures++; $display("[TB] FAIL pad_clean_lead: got %b expected 0", ifc.pad_err); end
        sendByte(8'h05);
        checks++; if (ifc.pad_err !== 1'b1) begin failures++; $display("[TB] FAIL pad_lead_err: got %b expected 1", ifc.pad_err); end
        sendByte(8'hAA); sendByte(8'hBB); sendByte(8'hCC); sendByte(8'hDD); sendByte(8'h00);
        popWord();
        exp = sb.pop_front();
        checks++; if (ifc.read_data !== exp) begin failures++; $display("[TB] FAIL pad_word: got %h expected %h", ifc.read_data, exp); end
        sendGroup(8'h00, 8'h00, 32'h12345678, 8'h00);
        popWord();
        exp = sb.pop_front();
        checks++; if (ifc.read_data !== exp) begin failures++; $display("[TB] FAIL pad_clean_word: got %h expected %h", ifc.read_data, exp); end
        checks++; if (ifc.pad_err !== 1'b1) begin failures++; $display("[TB] FAIL pad_sticky: got %b expected 1", ifc.pad_err); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        lastRead = '0;
        checks++; if (ifc.pad_err !== 1'b0) begin failures++; $display("[TB] FAIL pad_reset_clear: got %b expected 0", ifc.pad_err); end
        sb.push_back(32'h9ABCDEF0);
        sendByte(8'h00); sendByte(8'h00); sendByte(8'h9A); sendByte(8'hBC); sendByte(8'hDE); sendByte(8'hF0);
        checks++; if (ifc.pad_err !== 1'b0) begin failures++; $display("[TB] FAIL pad_data_not_pad: got %b expected 0", ifc.pad_err); end
        sendByte(8'h01);
        checks++; if (ifc.pad_err !== 1'b1) begin failures++; $display("[TB] FAIL pad_trail_err: got %b expected 1", ifc.pad_err); end
        popWord();
        exp = sb.pop_front();
        checks++; if (ifc.read_data !== exp) begin failures++; $display("[TB] FAIL pad_trail_word: got %h expected %h", ifc.read_data, exp); end
        lastRead = exp;
    endtask

    task automatic test_read_empty_stall();
        logic [31:0] w;
        logic [31:0] exp;
        for (int i = 0; i < 3; i++) begin
            ifc.read_en = 1'b1;
            tick();
            ifc.read_en = 1'b0;
            tick();
            checks++; if (ifc.read_data !== lastRead) begin failures++; $display("[TB] FAIL empty_read_hold%0d: got %h expected %h", i, ifc.read_data, lastRead); end
            checks++; if (ifc.empty !== 1'b1) begin failures++; $display("[TB] FAIL empty_read_flag%0d: got %b expected 1", i, ifc.empty); end
        end
        w = 32'h600DF00D;
        sb.push_back(w);
        for (int i = 0; i < 7; i++) begin
            case (i)
                2:       sendByte(w[31:24]);
                3:       sendByte(w[23:16]);
                4:       sendByte(w[15:8]);
                5:       sendByte(w[7:0]);
                default: sendByte(8'h00);
            endcase
            ifc.in_data = 8'($urandom_range(1, 255));
            tick();
            tick();
        end
        popWord();
        exp = sb.pop_front();
        checks++; if (ifc.read_data !== exp) begin failures++; $display("[TB] FAIL gapped_word: got %h expected %h", ifc.read_data, exp); end
        lastRead = exp;
        checks++; if (ifc.pad_err !== 1'b1) begin failures++; $display("[TB] FAIL gapped_pad_err: got %b expected 1", ifc.pad_err); end
    endtask

    task automatic test_async_reset();
        logic [31:0] exp;
        sendGroup(8'h00, 8'h00, 32'hCAFEBABE, 8'h00);
        checks++; if (ifc.empty !== 1'b0) begin failures++; $display("[TB] FAIL areset_pre_empty: got %b expected 0", ifc.empty); end
        sendByte(8'h09); sendByte(8'h00); sendByte(8'h11); sendByte(8'h22);
        #3;
        rst = 1'b0;
        #1;
        checks++; if (ifc.read_data !== 32'h0) begin failures++; $display("[TB] FAIL areset_read_data: got %h expected 0", ifc.read_data); end
        checks++; if (ifc.empty !== 1'b1) begin failures++; $display("[TB] FAIL areset_empty: got %b expected 1", ifc.empty); end
        checks++; if (ifc.full !== 1'b0) begin failures++; $display("[TB] FAIL areset_full: got %b expected 0", ifc.full); end
        checks++; if (ifc.pad_err !== 1'b0) begin failures++; $display("[TB] FAIL areset_pad_err: got %b expected 0", ifc.pad_err); end
        checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL areset_in_ready: got %b expected 1", ifc.in_ready); end
        sb.delete();
        lastRead = '0;
        tick();
        rst = 1'b1;
        tick();
        sendGroup(8'h00, 8'h00, 32'h55667788, 8'h00);
        popWord();
        exp = sb.pop_front();
        checks++; if (ifc.read_data !== exp) begin failures++; $display("[TB] FAIL areset_resync_word: got %h expected %h", ifc.read_data, exp); end
        checks++; if (ifc.empty !== 1'b1) begin failures++; $display("[TB] FAIL areset_final_empty: got %b expected 1", ifc.empty); end
        checks++; if (ifc.pad_err !== 1'b0) begin failures++; $display("[TB] FAIL areset_final_pad_err: got %b expected 0", ifc.pad_err); end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_unpack();
        test_fill_backpressure();
        test_simultaneous();
        test_pad_error();
        test_read_empty_stall();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_out3.md
Name: fifo_out3

Overview:
- Receive-side counterpart of the padded byte-stream FIFO in the Q_PROJECTION path.
- Accepts a byte stream framed in 7-byte groups: 2 leading zero pads, 4 data bytes, 1 trailing zero pad.
- Strips the pads, reassembles each group's 4 data bytes into one 32-bit word and buffers the words in a small FIFO for the downstream consumer.

Parameters:
- DATA_WIDTH, 8, byte width of the input stream; the output word is 4*DATA_WIDTH.
- DEPTH, 4, word FIFO capacity in 32-bit words; any integer >= 2, not required to be a power of 2.
- LEAD_PAD, 2, number of leading pad bytes per group.
- TRAIL_PAD, 1, number of trailing pad bytes per group. Group length is GRP = LEAD_PAD+4+TRAIL_PAD = 7.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset; rst=0 resets all state immediately.
- in_valid  in  1  input byte valid.
- in_data  in  DATA_WIDTH  input byte.
- in_ready  out  1  byte is accepted when in_valid && in_ready at a clk edge.
- read_en  in  1  pop request.
- read_data  out  4*DATA_WIDTH  popped word, registered.
- full  out  1  word FIFO holds DEPTH words.
- empty  out  1  word FIFO holds 0 words.
- pad_err  out  1  sticky flag: a pad byte was nonzero.

Behaviour:
- Reset values: read_data=0, full=0, empty=1, pad_err=0. Internally pos=0, word count=0, rd/wr pointers=0, assembly register=0. in_ready=1 immediately after reset.
- pos counts 0..GRP-1 and advances only on an accepted byte. It wraps from GRP-1 to 0.
- Pad bytes: positions < LEAD_PAD and positions >= LEAD_PAD+4.
  - A pad byte is accepted and discarded.
  - If the byte is nonzero, pad_err is set to 1 and stays set until reset.
  - Framing is not resynchronised; pos still advances.
- Data bytes: positions LEAD_PAD..LEAD_PAD+3 are stored big-endian. The first data byte goes to [31:24]; the last goes to [7:0].
- Word push: happens on the clk edge that accepts position LEAD_PAD+3. The word is the three held bytes plus the current in_data. It is written to mem[wr_ptr], and wr_ptr advances (wr_ptr+1)%DEPTH.
- Backpressure: in_ready = !(pos==LEAD_PAD+3 && full).
  - in_ready is combinational from registered state only; there is no path from read_en.
  - Pad bytes and the first three data bytes are always accepted.
- Pop: when read_en && !empty at a clk edge:
  - read_data <= mem[rd_ptr], valid the following cycle (1-cycle latency);
  - rd_ptr advances (rd_ptr+1)%DEPTH.
  - read_data holds its value when no pop occurs.
  - read_en while empty is ignored: no state change and read_data holds.
- Count: push only -> +1; pop only -> -1; push and pop on the same edge -> unchanged.
  - A simultaneous push and pop at count 0 cannot occur, because a pop requires !empty.
  - A push while full cannot occur, because in_ready=0.
- full = (count==DEPTH); empty = (count==0). Both are combinational from count.
- Pointers wrap modulo DEPTH. Count width is $clog2(DEPTH)+1.
- Reset mid-group: a partial group is discarded and pos returns to 0. The upstream sender must restart on a group boundary.
- in_data is don't-care when in_valid=0; pos does not advance.

Test Plan:
1. Basic unpack: after reset, send 00 00 DE AD BE EF 00 -> empty falls after the 6th byte's edge. read_en one cycle -> read_data=32'hDEADBEEF next cycle; empty=1; pad_err=0.
2. Fill and backpressure (DEPTH=4): send 5 groups with data words 0x01020304, 0x11121314, 0x21222324, 0x31323334, 0x41424344, no reads.
   - full=1 after the 4th group.
   - 5th group: bytes at positions 0-4 are accepted, then in_ready=0 holding 0x44.
   - One pop returns 0x01020304; in_ready returns to 1, 0x44 is accepted, and the word 0x41424344 is pushed.
   - The following 4 pops return 0x11121314, 0x21222324, 0x31323334, 0x41424344 in order.
3. Simultaneous push and pop: with count=2, pop on the same edge that accepts position 5 -> count stays 2; FIFO order is preserved across pointer wrap over 3*DEPTH words.
4. Pad error: send 00 05 AA BB CC DD 00 -> pad_err=1 and word 0xAABBCCDD is stored. A later clean group keeps pad_err=1; reset clears it.
5. Read on empty and stalled input: toggle read_en with an empty FIFO -> read_data unchanged, empty=1. Send a group with in_valid gaps between every byte -> the same word results.
6. Async reset mid-group: assert rst=0 between clock edges after 4 bytes -> outputs reach reset values without a clock edge. The next full group is decoded correctly from pos 0.
